// File: rtl/pipe_stall_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: drives F/D/E/M/W enables and clears,
// and sequences the iterative divider. Optional stall counter enabled by PIPE_STALL_CNT_EN.
module pipe_stall_ctrl #(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] ex_rt,
  input  logic       ex_mem_read,
  input  logic       id_flush,
  input  logic       ex_div_start,
  input  logic       mem_req,
  input  logic       mem_ack,
  input  logic       exc_valid,
  output logic       en_f,
  output logic       en_d,
  output logic       en_e,
  output logic       en_m,
  output logic       en_w,
  output logic       clr_d,
  output logic       clr_e,
  output logic       clr_m,
  output logic       clr_w,
  output logic       div_busy,
  output logic       div_done
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_BUSY = 2'd1,
    D_DONE = 2'd2
  } div_state_t;

  div_state_t       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  logic mem_stall;
  logic lu;
  logic div_stall;

  assign mem_stall = mem_req & ~mem_ack;
  assign lu        = ex_mem_read & (ex_rt != 5'd0) & ((ex_rt == id_rs) | (ex_rt == id_rt));
  assign div_stall = ((state == D_IDLE) & ex_div_start & ~mem_stall) | (state == D_BUSY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= D_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (exc_valid) begin
      state_nx = D_IDLE;
      cnt_nx   = '0;
    end else begin
      case (state)
        D_IDLE: begin
          if (ex_div_start && !mem_stall) begin
            state_nx = D_BUSY;
            cnt_nx   = CNT_W'(DIV_CYCLES - 1);
          end
        end
        D_BUSY: begin
          // Counting is independent of memory stalls.
          cnt_nx = cnt - 1'b1;
          if (cnt == CNT_W'(1)) state_nx = D_DONE;
        end
        D_DONE: begin
          if (!mem_stall) state_nx = D_IDLE;
        end
        default: begin
          state_nx = D_IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  always_comb begin
    en_f     = 1'b1;
    en_d     = 1'b1;
    en_e     = 1'b1;
    en_m     = 1'b1;
    en_w     = 1'b1;
    clr_d    = 1'b0;
    clr_e    = 1'b0;
    clr_m    = 1'b0;
    clr_w    = 1'b0;
    div_busy = (state == D_BUSY);
    div_done = (state == D_DONE);
    // Reset forces idle outputs even while a divide request is still presented.
    if (rst) begin
      div_busy = 1'b0;
      div_done = 1'b0;
    end else if (exc_valid) begin
      clr_d = 1'b1;
      clr_e = 1'b1;
      clr_m = 1'b1;
      clr_w = 1'b1;
    end else if (mem_stall) begin
      en_f  = 1'b0;
      en_d  = 1'b0;
      en_e  = 1'b0;
      en_m  = 1'b0;
      clr_w = 1'b1;
    end else if (div_stall) begin
      en_f  = 1'b0;
      en_d  = 1'b0;
      en_e  = 1'b0;
      clr_m = 1'b1;
    end else if (lu) begin
      en_f  = 1'b0;
      en_d  = 1'b0;
      clr_e = 1'b1;
    end else if (id_flush) begin
      clr_d = 1'b1;
    end
  end

`ifdef PIPE_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        stall_cycles <= '0;
    else if (!en_f) stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed self-checking bench for pipe_stall_ctrl: vector table plus multi-cycle sequences.
// Stall counter checks are compiled in when PIPE_STALL_CNT_EN is defined.
module tb_pipe_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       ex_mem_read, id_flush, ex_div_start, mem_req, mem_ack, exc_valid;
  logic       en_f, en_d, en_e, en_m, en_w;
  logic       clr_d, clr_e, clr_m, clr_w;
  logic       div_busy, div_done;
`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  pipe_stall_ctrl #(.DIV_CYCLES(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .ex_rt(ex_rt),
    .ex_mem_read(ex_mem_read), .id_flush(id_flush), .ex_div_start(ex_div_start),
    .mem_req(mem_req), .mem_ack(mem_ack), .exc_valid(exc_valid),
    .en_f(en_f), .en_d(en_d), .en_e(en_e), .en_m(en_m), .en_w(en_w),
    .clr_d(clr_d), .clr_e(clr_e), .clr_m(clr_m), .clr_w(clr_w),
    .div_busy(div_busy), .div_done(div_done)
`ifdef PIPE_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs, rt, xrt;
    logic [5:0] ctl;   // {ex_mem_read, id_flush, ex_div_start, mem_req, mem_ack, exc_valid}
    logic [4:0] en;    // {f,d,e,m,w}
    logic [3:0] clr;   // {d,e,m,w}
  } vec_t;

  vec_t vt[14];

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] xrt,
                              input logic [5:0] ctl, input logic [4:0] en, input logic [3:0] clr);
    vec_t v;
    v.rs = rs; v.rt = rt; v.xrt = xrt; v.ctl = ctl; v.en = en; v.clr = clr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; ex_rt = '0;
    ex_mem_read = 1'b0; id_flush = 1'b0; ex_div_start = 1'b0;
    mem_req = 1'b0; mem_ack = 1'b0; exc_valid = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] en_vec();
    return {en_f, en_d, en_e, en_m, en_w};
  endfunction

  function automatic logic [3:0] clr_vec();
    return {clr_d, clr_e, clr_m, clr_w};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ctl = {mrd, flush, start, req, ack, exc}
    vt[0]  = mk(5'd0, 5'd0, 5'd0, 6'b000000, 5'b11111, 4'b0000);
    vt[1]  = mk(5'd5, 5'd0, 5'd5, 6'b100000, 5'b00111, 4'b0100);
    vt[2]  = mk(5'd3, 5'd7, 5'd7, 6'b100000, 5'b00111, 4'b0100);
    vt[3]  = mk(5'd0, 5'd0, 5'd0, 6'b100000, 5'b11111, 4'b0000);
    vt[4]  = mk(5'd5, 5'd0, 5'd5, 6'b000000, 5'b11111, 4'b0000);
    vt[5]  = mk(5'd0, 5'd0, 5'd0, 6'b010000, 5'b11111, 4'b1000);
    vt[6]  = mk(5'd9, 5'd0, 5'd9, 6'b110000, 5'b00111, 4'b0100);
    vt[7]  = mk(5'd0, 5'd0, 5'd0, 6'b000100, 5'b00001, 4'b0001);
    vt[8]  = mk(5'd0, 5'd0, 5'd0, 6'b000110, 5'b11111, 4'b0000);
    vt[9]  = mk(5'd4, 5'd0, 5'd4, 6'b100100, 5'b00001, 4'b0001);
    vt[10] = mk(5'd0, 5'd0, 5'd0, 6'b000001, 5'b11111, 4'b1111);
    vt[11] = mk(5'd6, 5'd6, 5'd6, 6'b110101, 5'b11111, 4'b1111);
    vt[12] = mk(5'd0, 5'd0, 5'd0, 6'b001100, 5'b00001, 4'b0001);
    vt[13] = mk(5'd0, 5'd0, 5'd0, 6'b001001, 5'b11111, 4'b1111);

    clear_inputs();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rst_en", 32'(en_vec()), 32'h1f);
    chk("rst_clr", 32'(clr_vec()), 32'h0);
    chk("rst_div", 32'({div_busy, div_done}), 32'h0);
`ifdef PIPE_STALL_CNT_EN
    chk("rst_cnt", stall_cycles, 32'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;

    // Divide of 32 starting in relative cycle 0
    ex_div_start = 1'b1;
    for (int k = 0; k <= 32; k++) begin
      logic st;
      st = (k <= 31);
      @(negedge clk);
      chk($sformatf("div_seq_c%0d", k), 32'({en_f, en_e, clr_m, div_busy, div_done}),
          32'({~st, ~st, st, (k >= 1 && k <= 31), (k == 32)}));
      next_cycle();
    end
    ex_div_start = 1'b0;
    @(negedge clk);
    chk("div_idle", 32'({en_vec(), div_busy, div_done}), 32'({5'h1f, 2'b00}));
    next_cycle();

    // One load-use bubble, then no stall once the hazard is gone
    ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    @(negedge clk);
    chk("lu_hit", 32'({en_vec(), clr_vec()}), 32'({5'b00111, 4'b0100}));
    next_cycle();
    clear_inputs();
    @(negedge clk);
    chk("lu_after", 32'({en_vec(), clr_vec()}), 32'({5'h1f, 4'h0}));
`ifdef PIPE_STALL_CNT_EN
    chk("cnt_33", stall_cycles, 32'd33);
`endif
    next_cycle();

    for (int i = 0; i < 14; i++) begin
      id_rs = vt[i].rs; id_rt = vt[i].rt; ex_rt = vt[i].xrt;
      {ex_mem_read, id_flush, ex_div_start, mem_req, mem_ack, exc_valid} = vt[i].ctl;
      @(negedge clk);
      chk($sformatf("vec%0d_en", i), 32'(en_vec()), 32'(vt[i].en));
      chk($sformatf("vec%0d_clr", i), 32'(clr_vec()), 32'(vt[i].clr));
      chk($sformatf("vec%0d_div", i), 32'({div_busy, div_done}), 32'h0);
      next_cycle();
    end
    clear_inputs();
    next_cycle();

    // Memory wait: three stalled cycles then ack
    mem_req = 1'b1;
    for (int k = 0; k <= 3; k++) begin
      mem_ack = (k == 3);
      @(negedge clk);
      chk($sformatf("mem_c%0d", k), 32'({en_m, clr_w, en_w}), (k < 3) ? 32'b011 : 32'b101);
      next_cycle();
    end
    clear_inputs();

    // Exception arriving in divider cycle 5
    ex_div_start = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      if (k == 5) exc_valid = 1'b1;
      @(negedge clk);
      if (k == 5) begin
        chk("exc_clr", 32'(clr_vec()), 32'hf);
        chk("exc_en", 32'(en_vec()), 32'h1f);
      end else begin
        chk($sformatf("exc_pre_c%0d", k), 32'({div_busy, en_e}), 32'({(k >= 1), 1'b0}));
      end
      next_cycle();
    end
    clear_inputs();
    @(negedge clk);
    chk("exc_after", 32'({div_busy, div_done, en_vec(), clr_vec()}), 32'({2'b00, 5'h1f, 4'h0}));
    next_cycle();

    // Divider completes while a memory stall spans D_DONE
    ex_div_start = 1'b1;
    for (int k = 0; k <= 35; k++) begin
      logic ms;
      ms = (k >= 30 && k <= 34);
      mem_req = (k >= 30);
      mem_ack = (k == 35);
      @(negedge clk);
      chk($sformatf("divmem_c%0d", k), 32'({div_busy, div_done, en_e, en_m, clr_m, clr_w}),
          32'({(k >= 1 && k <= 31), (k >= 32), ~(ms | (k <= 31)), ~ms, (~ms & (k <= 31)), ms}));
      next_cycle();
    end
    clear_inputs();
    @(negedge clk);
    chk("divmem_idle", 32'({div_busy, div_done, en_e}), 32'b001);
    next_cycle();

    // Reset mid-division releases the stall immediately
    ex_div_start = 1'b1;
    repeat (10) next_cycle();
    @(negedge clk);
    chk("rstmid_pre", 32'({div_busy, en_e}), 32'b10);
    #1 rst = 1'b1;
    #1;
    chk("rstmid_en", 32'({div_busy, div_done, en_vec(), clr_vec()}), 32'({2'b00, 5'h1f, 4'h0}));
`ifdef PIPE_STALL_CNT_EN
    chk("rstmid_cnt", stall_cycles, 32'd0);
`endif
    next_cycle();
    rst = 1'b0;
    ex_div_start = 1'b0;
    @(negedge clk);
    chk("rstmid_after", 32'({div_busy, div_done, en_vec()}), 32'({2'b00, 5'h1f}));
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
